mem_cmd_master: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 28 ++
 rtl/mem_cmd_master.sv | 132 +++++++++++++
 tb/tb_mem_cmd_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// mem_bus_pkg : shared memory-bus command encodings, widths and master states
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bus_pkg;

    localparam int CMD_W  = 5;
    localparam int DATA_W = 8;

    localparam logic [CMD_W-1:0] CMD_NOP   = 5'd0;
    localparam logic [CMD_W-1:0] CMD_ADDR  = 5'd1;
    localparam logic [CMD_W-1:0] CMD_WRITE = 5'd2;
    localparam logic [CMD_W-1:0] CMD_READ  = 5'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WR      = 3'd2,
        ST_RD      = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_cmd_master.sv
// ============================================================================
// mem_cmd_master : turns a valid/ready read/write request stream into the
//                  ADDR/WRITE/READ command sequence on the shared memory bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_cmd_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic [CMD_W-1:0]  cmd,
    inout  wire  [DATA_W-1:0] data,
    output logic              busy
);

    localparam logic [3:0] LAT = 4'(READ_LAT);

    state_t              state;
    state_t              next_state;
    logic                write_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [3:0]          wait_cnt;
    logic                accept;
    logic                last_wait;

    logic [CMD_W-1:0]    cmd_reg;
    logic [CMD_W-1:0]    cmd_nxt;
    logic                data_oe;
    logic                oe_nxt;
    logic [DATA_W-1:0]   dout;
    logic [DATA_W-1:0]   dout_nxt;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign last_wait = (state == ST_RD_WAIT) && (wait_cnt == 4'd1);
    assign rsp_valid = (state == ST_RSP);
    assign busy      = (state != ST_IDLE);
    assign cmd       = cmd_reg;
    assign data      = data_oe ? dout : {DATA_W{1'bz}};

    // State and bus outputs are registered together so cmd/data follow state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cmd_reg <= CMD_NOP;
            data_oe <= 1'b0;
            dout    <= '0;
        end else begin
            state   <= next_state;
            cmd_reg <= cmd_nxt;
            data_oe <= oe_nxt;
            dout    <= dout_nxt;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (accept) next_state = ST_ADDR;
            ST_ADDR:    next_state = write_reg ? ST_WR : ST_RD;
            ST_WR:      next_state = ST_RSP;
            ST_RD:      next_state = ST_RD_WAIT;
            ST_RD_WAIT: if (wait_cnt == 4'd1) next_state = ST_RSP;
            ST_RSP:     if (rsp_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // ADDR is only entered from IDLE on accept, so the address comes straight off the request.
    always_comb begin
        cmd_nxt  = CMD_NOP;
        oe_nxt   = 1'b0;
        dout_nxt = '0;
        case (next_state)
            ST_ADDR: begin
                cmd_nxt  = CMD_ADDR;
                oe_nxt   = 1'b1;
                dout_nxt = DATA_W'(req_addr);
            end
            ST_WR: begin
                cmd_nxt  = CMD_WRITE;
                oe_nxt   = 1'b1;
                dout_nxt = wdata_reg;
            end
            ST_RD:   cmd_nxt = CMD_READ;
            default: cmd_nxt = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg <= 1'b0;
            wdata_reg <= '0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_write <= 1'b0;
        end else begin
            if (accept) begin
                write_reg <= req_write;
                wdata_reg <= req_wdata;
            end
            if (state == ST_RD)
                wait_cnt <= LAT;
            else if (state == ST_RD_WAIT)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == ST_WR) begin
                rsp_rdata <= '0;
                rsp_write <= 1'b1;
            end else if (last_wait) begin
                rsp_rdata <= data;
                rsp_write <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_cmd_master.sv
// ============================================================================
// tb_mem_cmd_master : directed, table-driven bench with a behavioural memmod
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_cmd_master;
    import mem_bus_pkg::*;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_wdata = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_rdata;
    logic        rsp_write;
    logic [4:0]  cmd;
    wire  [7:0]  data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_cmd_master #(.ADDR_W(8), .READ_LAT(RL)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_write(rsp_write), .cmd(cmd), .data(data), .busy(busy)
    );

    // Extra instances only to measure response latency at the READ_LAT extremes.
    logic [1:0] lv = 2'b00;
    logic [1:0] lready, lvalid, lrw, lbusy;
    logic [7:0] lrd1, lrd15;
    logic [4:0] lcmd1, lcmd15;
    wire  [7:0] ld1, ld15;

    mem_cmd_master #(.ADDR_W(8), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(lv[0]), .req_ready(lready[0]), .req_write(1'b0),
        .req_addr(8'h07), .req_wdata(8'h00),
        .rsp_valid(lvalid[0]), .rsp_ready(1'b1), .rsp_rdata(lrd1),
        .rsp_write(lrw[0]), .cmd(lcmd1), .data(ld1), .busy(lbusy[0])
    );

    mem_cmd_master #(.ADDR_W(8), .READ_LAT(15)) u_lat15 (
        .clk(clk), .rst(rst),
        .req_valid(lv[1]), .req_ready(lready[1]), .req_write(1'b0),
        .req_addr(8'h07), .req_wdata(8'h00),
        .rsp_valid(lvalid[1]), .rsp_ready(1'b1), .rsp_rdata(lrd15),
        .rsp_write(lrw[1]), .cmd(lcmd15), .data(ld15), .busy(lbusy[1])
    );

    // Behavioural memmod: latches address, writes, and drives read data
    // for READ_LAT cycles following the READ command cycle.
    logic [7:0] mem [256];
    logic [7:0] mm_addr;
    logic [7:0] mm_rd;
    logic [3:0] mm_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_cnt  <= 4'd0;
            mm_addr <= 8'h00;
            mm_rd   <= 8'h00;
        end else begin
            if (cmd == CMD_ADDR)  mm_addr <= data;
            if (cmd == CMD_WRITE) mem[mm_addr] <= data;
            if (cmd == CMD_READ) begin
                mm_cnt <= 4'(RL);
                mm_rd  <= mem[mm_addr];
            end else if (mm_cnt != 4'd0) begin
                mm_cnt <= mm_cnt - 4'd1;
            end
        end
    end

    assign data = (mm_cnt != 4'd0) ? mm_rd : 8'bzzzzzzzz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rd;
    } vec_t;

    // One complete request with rsp_ready high: checks bus sequence, latency and response.
    task automatic run_req(input logic w, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] exp_rd);
        int g;
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = ~a; req_wdata = ~wd; req_write = ~w;
        chk("cmd_addr", 32'(cmd), 32'(CMD_ADDR));
        chk("data_addr", 32'(data), 32'(a));
        chk("busy_addr", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("cmd_op", 32'(cmd), w ? 32'(CMD_WRITE) : 32'(CMD_READ));
        if (w) chk("data_wdata", 32'(data), 32'(wd));
        cyc = 2;
        while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
        chk("rsp_latency", 32'(cyc), w ? 32'd3 : 32'(3 + RL));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("rsp_write", 32'(rsp_write), 32'(w));
        chk("cmd_rsp_nop", 32'(cmd), 32'(CMD_NOP));
        @(posedge clk); #1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        int f1, f15, seen;
        logic [7:0] bw_a [3];
        logic [7:0] bw_d [3];
        logic       bw_w [3];
        logic [7:0] bexp_rd [3];

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int f1, f15, seen, g;
        logic [7:0] bw_a [3];
        logic [7:0] bw_d [3];
        logic       bw_w [3];
        logic [7:0] bexp_rd [3];

        vecs[0] = '{w:1'b1, a:8'h12, wd:8'hA5, exp_rd:8'h00};
        vecs[1] = '{w:1'b0, a:8'h12, wd:8'h00, exp_rd:8'hA5};
        vecs[2] = '{w:1'b0, a:8'h07, wd:8'h00, exp_rd:8'h3C};
        vecs[3] = '{w:1'b1, a:8'hFF, wd:8'h5A, exp_rd:8'h00};
        vecs[4] = '{w:1'b0, a:8'hFF, wd:8'h00, exp_rd:8'h5A};
        vecs[5] = '{w:1'b1, a:8'h00, wd:8'hC3, exp_rd:8'h00};
        vecs[6] = '{w:1'b0, a:8'h00, wd:8'h00, exp_rd:8'hC3};

        bw_w = '{1'b1, 1'b1, 1'b0};
        bw_a = '{8'h01, 8'h02, 8'h01};
        bw_d = '{8'h11, 8'h22, 8'h00};
        bexp_rd = '{8'h00, 8'h00, 8'h11};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h07] = 8'h3C;

        // Reset state
        #12;
        chk("rst_cmd", 32'(cmd), 32'(CMD_NOP));
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_write", 32'(rsp_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Latency at READ_LAT = 1 and 15
        lv = 2'b11;
        @(posedge clk); #1;
        lv = 2'b00;
        f1 = 0; f15 = 0;
        for (int c = 1; c <= 25; c++) begin
            if (lvalid[0] && f1 == 0) f1 = c;
            if (lvalid[1] && f15 == 0) f15 = c;
            @(posedge clk); #1;
        end
        chk("lat1_rsp_cycle", 32'(f1), 32'd4);
        chk("lat15_rsp_cycle", 32'(f15), 32'd18);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++)
            run_req(vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp_rd);

        // Back-to-back with req_valid held high
        @(negedge clk);
        fork
            begin : drv
                int gd;
                for (int i = 0; i < 3; i++) begin
                    req_write = bw_w[i]; req_addr = bw_a[i]; req_wdata = bw_d[i];
                    req_valid = 1'b1;
                    gd = 0;
                    while (!req_ready && gd < 40) begin @(negedge clk); gd++; end
                    chk("b2b_accept", 32'(req_ready), 32'd1);
                    @(posedge clk); #1;
                end
                req_valid = 1'b0;
            end
            begin : mon
                int gm;
                for (int j = 0; j < 3; j++) begin
                    gm = 0;
                    @(negedge clk);
                    while (!rsp_valid && gm < 60) begin
                        chk("b2b_ready_idle", 32'(req_ready), 32'(!busy));
                        @(negedge clk); gm++;
                    end
                    chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("b2b_rsp_write", 32'(rsp_write), 32'(bw_w[j]));
                    chk("b2b_rsp_rdata", 32'(rsp_rdata), 32'(bexp_rd[j]));
                    @(posedge clk);
                end
            end
        join

        // Response back-pressure: rsp_ready low for 6 cycles with another request waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h07; req_wdata = 8'h00;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 8'h30; req_wdata = 8'h77;
        g = 0;
        while (!rsp_valid && g < 40) begin @(posedge clk); #1; g++; end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_rdata", 32'(rsp_rdata), 32'h3C);
            chk("stall_rsp_write", 32'(rsp_write), 32'd0);
            chk("stall_no_accept", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_idle_after", 32'(busy), 32'd0);
        chk("stall_ready_after", 32'(req_ready), 32'd1);
        req_valid = 1'b0;

        // Reset pulsed during RD_WAIT
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h07;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd", 32'(cmd), 32'(CMD_NOP));
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("no_rsp_after_rst", 32'(seen), 32'd0);
        run_req(1'b0, 8'h12, 8'h00, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
